// File: rtl/push_conditioner.sv
// Front-panel push-button conditioner: two-flop synchronizer, counter debouncer and
// one-cycle press/release strobes per button. Define PUSH_AUTO_REPEAT_EN for hold-to-repeat.
`timescale 1ns/1ps

module push_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic             clk_osc,
  input  logic             reset,
  input  logic [N_BTN-1:0] push_raw,
  output logic [N_BTN-1:0] push_level,
  output logic [N_BTN-1:0] push_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_pressed
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef PUSH_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_d;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      any_pressed <= 1'b0;
    end else begin
      sync1       <= push_raw;
      sync2       <= sync1;
      any_pressed <= |level_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : gen_btn
    logic             s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, push_q, rel_q;
    logic             push_d, rel_d;
`ifdef PUSH_AUTO_REPEAT_EN
    logic             fired_q, fired_d;
`endif

    assign s = sync2[i];

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d[i] = level_q;
      push_d     = 1'b0;
      rel_d      = 1'b0;
`ifdef PUSH_AUTO_REPEAT_EN
      fired_d    = fired_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DEB_LAST) begin
            state_d    = ST_HELD;
            level_d[i] = 1'b1;
            push_d     = 1'b1;
            cnt_d      = CNT_ZERO;
`ifdef PUSH_AUTO_REPEAT_EN
            fired_d    = 1'b0;
`endif
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_HELD: begin
          if (!s) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
`ifdef PUSH_AUTO_REPEAT_EN
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (cnt_q == (fired_q ? PER_LAST : DLY_LAST)) begin
              push_d  = 1'b1;
              cnt_d   = CNT_ZERO;
              fired_d = 1'b1;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
`else
            cnt_d = cnt_q;
`endif
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state_d = ST_HELD;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DEB_LAST) begin
            state_d    = ST_IDLE;
            level_d[i] = 1'b0;
            rel_d      = 1'b1;
            cnt_d      = CNT_ZERO;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_ZERO;
        level_q <= 1'b0;
        push_q  <= 1'b0;
        rel_q   <= 1'b0;
`ifdef PUSH_AUTO_REPEAT_EN
        fired_q <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d[i];
        push_q  <= push_d;
        rel_q   <= rel_d;
`ifdef PUSH_AUTO_REPEAT_EN
        fired_q <= fired_d;
`endif
      end
    end

    assign push_level[i]    = level_q;
    assign push_pulse[i]    = push_q;
    assign release_pulse[i] = rel_q;
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench for push_conditioner: directed scenarios plus randomized button
// activity, all compared against a run-length reference model of the debouncer.
`timescale 1ns/1ps

module tb_push_conditioner;
  localparam int N   = 5;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 5;

  logic         clk_osc = 1'b0;
  logic         reset;
  logic [N-1:0] push_raw;
  logic [N-1:0] push_level, push_pulse, release_pulse;
  logic         any_pressed;

  push_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(8)
  ) dut (
    .clk_osc(clk_osc), .reset(reset), .push_raw(push_raw), .push_level(push_level),
    .push_pulse(push_pulse), .release_pulse(release_pulse), .any_pressed(any_pressed)
  );

  always #5 clk_osc = ~clk_osc;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: raw delayed two samples; a level change is accepted once the
  // delayed input has disagreed with the level for DEB consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pp, m_rp;
  int           m_run[N];
  int           m_since[N];
  bit           m_fired[N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pp = '0; m_rp = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_since[i] = 0; m_fired[i] = 0;
    end
  endtask

  task automatic model_tick();
    logic [N-1:0] s;
    s = m_s2; m_s2 = m_s1; m_s1 = push_raw;
    m_pp = '0; m_rp = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
          if (s[i]) begin
            m_pp[i] = 1'b1; m_since[i] = 0; m_fired[i] = 0;
          end else begin
            m_rp[i] = 1'b1;
          end
        end
      end else begin
        if (m_lvl[i]) begin
          if (m_run[i] > 0) m_since[i] = 0;
          else begin
            m_since[i]++;
`ifdef PUSH_AUTO_REPEAT_EN
            if (m_since[i] == (m_fired[i] ? PER : DLY)) begin
              m_pp[i] = 1'b1; m_since[i] = 0; m_fired[i] = 1;
            end
`endif
          end
        end
        m_run[i] = 0;
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared at the following negedge.
  task automatic step();
    @(posedge clk_osc);
    model_tick();
    @(negedge clk_osc);
    check("cyc_level",   push_level,    m_lvl);
    check("cyc_pulse",   push_pulse,    m_pp);
    check("cyc_release", release_pulse, m_rp);
    check("cyc_any",     any_pressed,   |m_lvl);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asserted between edges; outputs must drop before any clock arrives.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check("rst_async_level",   push_level,    0);
    check("rst_async_pulse",   push_pulse,    0);
    check("rst_async_release", release_pulse, 0);
    check("rst_async_any",     any_pressed,   0);
    @(posedge clk_osc);
    @(posedge clk_osc);
    @(negedge clk_osc);
    reset = 1'b0;
  endtask

  // Index (E0 = first edge) of the first push_pulse on bit b, or -1 on timeout.
  task automatic wait_push(input int b, output int idx);
    idx = -1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (push_pulse[b]) begin idx = n; break; end
    end
  endtask

  int idx, npulse, bounce_ev;
  int hold_left[N];

  initial begin
    reset    = 1'b1;
    push_raw = '0;
    model_reset();
    #1;
    check("reset_level", push_level,    0);
    check("reset_pulse", push_pulse,    0);
    check("reset_rel",   release_pulse, 0);
    check("reset_any",   any_pressed,   0);
    repeat (3) @(posedge clk_osc);
    @(negedge clk_osc);
    reset = 1'b0;
    settle(3);

    // Clean press on bit 0: accepted at E5 (E0 is the first edge after the raw rise).
    push_raw[0] = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      step();
      if (n == 4) check("press_e4_level", push_level, 0);
    end
    check("press_e5_pulse", push_pulse, 5'b00001);
    check("press_e5_level", push_level, 5'b00001);
    step();
    check("press_pulse_width", push_pulse, 0);
    settle(3);
    check("press_any_held", any_pressed, 1);

    // Release bit 0.
    push_raw[0] = 1'b0;
    idx = -1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (release_pulse[0]) begin idx = n; break; end
    end
    check("release_latency", idx, 5);
    check("release_level",   push_level[0], 0);
    check("release_any",     any_pressed, 0);
    step();
    check("release_width", release_pulse, 0);

    // Bounce on bit 2: 1,0,1,0 then quiet.
    bounce_ev = 0;
    for (int n = 0; n < 14; n++) begin
      push_raw[2] = (n < 4) ? ~n[0] : 1'b0;
      step();
      bounce_ev += int'(push_pulse[2]) + int'(release_pulse[2]) + int'(push_level[2]);
    end
    check("bounce_events", bounce_ev, 0);

    // Hold bit 1 for 30 cycles after acceptance.
    push_raw[1] = 1'b1;
    wait_push(1, idx);
    check("hold_accept_latency", idx, 5);
    npulse = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      npulse += int'(push_pulse[1]);
`ifdef PUSH_AUTO_REPEAT_EN
      check($sformatf("repeat_at_%0d", k), push_pulse[1], (k >= DLY && (k - DLY) % PER == 0));
`else
      check($sformatf("repeat_at_%0d", k), push_pulse[1], 0);
`endif
    end
`ifdef PUSH_AUTO_REPEAT_EN
    check("repeat_total", npulse, 6);
`else
    check("repeat_total", npulse, 1);
`endif
    push_raw[1] = 1'b0;
    settle(10);

    // Reset while bit 4 is held; button stays down and must re-debounce.
    push_raw[4] = 1'b1;
    wait_push(4, idx);
    check("rst_hold_accept", idx, 5);
    settle(3);
    check("rst_hold_level", push_level[4], 1);
    do_reset();
    wait_push(4, idx);
    check("rst_hold_redebounce", idx, 5);
    push_raw[4] = 1'b0;
    settle(10);

    // Simultaneous press on bits 0 and 3.
    push_raw[0] = 1'b1;
    push_raw[3] = 1'b1;
    settle(6);
    check("simul_e5_pulse", push_pulse, 5'b01001);
    push_raw = '0;
    settle(10);

    // Randomized activity: mix of short bounces and long holds, one reset midway.
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          push_raw[i]  = ~push_raw[i];
          hold_left[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                     : $urandom_range(5, 40);
        end
        hold_left[i]--;
      end
      if (c == 750) do_reset();
      else          step();
    end
    push_raw = '0;
    settle(12);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
